dac_serial_tx: RTL

Serial transmitter for the audio DAC: the output-side counterpart of the ADC serial receiver. Takes a 12-bit parallel sample on a start strobe and shifts it MSB-first into the DAC as a 16-bit frame, generating its own chip-select and serial clock from `clk100MHz`. It sits between the sample processing path and the DAC pins, and reports completion with a one-cycle `listo` pulse.

---
 rtl/dac_pkg.sv | 18 +
 rtl/dac_sclk_div.sv | 28 ++
 rtl/dac_serial_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the audio DAC serial transmitter.
package dac_pkg;

  localparam int FRAME_W = 16;
  localparam int CTRL_W  = 4;

  localparam logic [1:0] PD_NORMAL = 2'b00;

  // Control nibble sent ahead of the sample: two don't-care zeros, then the power-down bits.
  localparam logic [CTRL_W-1:0] CTRL_WORD = {2'b00, PD_NORMAL};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, held at zero otherwise.
module dac_sclk_div #(
  parameter int CLK_DIV = 1136
) (
  input  logic clk100MHz,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Shifts a control nibble plus sample MSB-first into the DAC with its own CS/sclk.
// Define DAC_DBUF_EN to add a one-entry holding register for requests made while busy.
module dac_serial_tx
  import dac_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 1136
) (
  input  logic              clk100MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] dato,
  input  logic              inicio,
  output logic              ocupado,
  output logic              listo,
  output logic              CS,
  output logic              sclk,
  output logic              datoDAC
);

  localparam int FW = CTRL_W + DATA_W;
  localparam int BW = $clog2(FW);

  state_t            state;
  logic [FW-1:0]     sr;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              start;
  logic [DATA_W-1:0] start_dat;
  logic [FW-1:0]     frame;

  dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .en        (state != IDLE),
    .tick      (tick)
  );

`ifdef DAC_DBUF_EN
  logic              hold_vld;
  logic [DATA_W-1:0] hold_dat;
  logic              hold_take;

  // A held sample follows straight on from the gap, so ocupado never drops between frames.
  assign hold_take = (state == GAP) && tick && hold_vld;

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (hold_take) begin
      hold_vld <= 1'b0;
    end else if (inicio && (state != IDLE) && !hold_vld && !((state == GAP) && tick)) begin
      hold_vld <= 1'b1;
      hold_dat <= dato;
    end
  end

  always_comb begin
    start     = 1'b0;
    start_dat = dato;
    if ((state == IDLE) && inicio) begin
      start = 1'b1;
    end else if (hold_take) begin
      start     = 1'b1;
      start_dat = hold_dat;
    end
  end
`else
  always_comb begin
    start     = (state == IDLE) && inicio;
    start_dat = dato;
  end
`endif

  assign frame = {CTRL_WORD, start_dat};

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      CS      <= 1'b1;
      sclk    <= 1'b1;
      datoDAC <= 1'b0;
      listo   <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (start) begin
        state   <= SHIFT;
        sr      <= frame;
        bit_cnt <= BW'(FW - 1);
        CS      <= 1'b0;
        datoDAC <= frame[FW-1];
        ocupado <= 1'b1;
      end else begin
        case (state)
          IDLE: ocupado <= 1'b0;
          SHIFT: begin
            if (tick) begin
              if (sclk) begin
                sclk <= 1'b0;
              end else if (bit_cnt == '0) begin
                sclk    <= 1'b1;
                CS      <= 1'b1;
                datoDAC <= 1'b0;
                listo   <= 1'b1;
                state   <= GAP;
              end else begin
                // Next bit changes on the rising edge, a full half-period before the DAC samples it.
                sclk    <= 1'b1;
                sr      <= {sr[FW-2:0], 1'b0};
                datoDAC <= sr[FW-2];
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end
          GAP: begin
            if (tick) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
